store_buffer: RTL

- FIFO store buffer between the memory stage and the data cache.
- Retired stores are queued here and later written into the data cache one at a time, in order.
- Loads check the buffer first. A match forwards the youngest store's data and asserts sb_hit, which suppresses the cache lookup.
- Word-granular only: every store writes a full 32-bit word.

---
 rtl/store_buffer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of retired word stores that drains one entry at a
// time into the data cache and forwards the youngest matching store to loads.
// Optional macro SB_COALESCE_EN merges a store into an already-buffered entry
// with the same word address instead of allocating a new one.
module store_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   st_valid,
   input  logic [AW-1:0]          st_addr,
   input  logic [DW-1:0]          st_data,
   output logic                   st_ready,
   input  logic                   ld_valid,
   input  logic [AW-1:0]          ld_addr,
   output logic                   sb_hit,
   output logic [DW-1:0]          sb_rd,
   input  logic                   ld_busy,
   output logic                   sb_write,
   output logic [AW-1:0]          sb_a,
   output logic [DW-1:0]          sb_wd,
   input  logic                   dc_hit,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned WW = AW - 2;

   typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [WW-1:0] r_addr [DEPTH];
   logic [DW-1:0] r_data [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic          w_push;
   logic          w_alloc;
   logic          w_pop;
   logic          w_coal;
   logic [PW-1:0] w_coal_idx;
   logic          w_ld_match;
   logic [PW-1:0] w_ld_idx;
   logic          w_unused_bits;

   assign w_unused_bits = ^{st_addr[1:0], ld_addr[1:0]};

   assign count    = r_count;
   assign empty    = (r_count == '0);
   assign full     = (r_count == CW'(DEPTH));
   assign st_ready = ~full | w_coal;
   assign w_push   = st_valid & st_ready;
   assign w_alloc  = w_push & ~w_coal;
   assign w_pop    = (r_state == DRAIN) & dc_hit;

   // Load forwarding: scan valid entries oldest to youngest, last match wins
   always_comb begin
      w_ld_match = 1'b0;
      w_ld_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < r_count) &&
             (r_addr[PW'(r_head + PW'(i))] == ld_addr[AW-1:2])) begin
            w_ld_match = 1'b1;
            w_ld_idx   = PW'(r_head + PW'(i));
         end
      end
   end

   assign sb_hit = ld_valid & w_ld_match;
   assign sb_rd  = sb_hit ? r_data[w_ld_idx] : '0;

`ifdef SB_COALESCE_EN
   logic          w_st_match;
   logic [PW-1:0] w_st_idx;

   // Store merge lookup: youngest valid entry with the incoming word address
   always_comb begin
      w_st_match = 1'b0;
      w_st_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < r_count) &&
             (r_addr[PW'(r_head + PW'(i))] == st_addr[AW-1:2])) begin
            w_st_match = 1'b1;
            w_st_idx   = PW'(r_head + PW'(i));
         end
      end
   end

   // The head entry being drained must stay stable, so it never absorbs a merge
   assign w_coal     = w_st_match & ~((w_st_idx == r_head) & (r_state == DRAIN));
   assign w_coal_idx = w_st_idx;
`else
   assign w_coal     = 1'b0;
   assign w_coal_idx = '0;
`endif

   // Drain FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Drain FSM next state and cache write interface
   always_comb begin
      w_state_nxt = r_state;
      sb_write    = 1'b0;
      sb_a        = '0;
      sb_wd       = '0;
      case (r_state)
         IDLE: begin
            if (~empty & ~ld_busy) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            sb_write = 1'b1;
            sb_a     = {r_addr[r_head], 2'b00};
            sb_wd    = r_data[r_head];
            if (dc_hit) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Head/tail pointers and occupancy counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_alloc) begin
            r_tail <= PW'(r_tail + 1'b1);
         end
         if (w_pop) begin
            r_head <= PW'(r_head + 1'b1);
         end
         case ({w_alloc, w_pop})
            2'b10:   r_count <= CW'(r_count + 1'b1);
            2'b01:   r_count <= CW'(r_count - 1'b1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage: allocate at tail, or overwrite data of a merged entry
   always_ff @(posedge clk) begin
      if (w_alloc) begin
         r_addr[r_tail] <= st_addr[AW-1:2];
         r_data[r_tail] <= st_data;
      end else if (w_push) begin
         r_data[w_coal_idx] <= st_data;
      end
   end

endmodule
